// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive datapath: ctrl phase encodings,
// the receiver's internal state type and small helper functions.
package uart_rx_pkg;

  localparam logic [3:0] CTRL_IDLE   = 4'b0000;
  localparam logic [3:0] CTRL_START  = 4'b0001;
  localparam logic [3:0] CTRL_DATA   = 4'b0010;
  localparam logic [3:0] CTRL_PARITY = 4'b0100;
  localparam logic [3:0] CTRL_STOP0  = 4'b1000;
  localparam logic [3:0] CTRL_STOP1  = 4'b1001;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    BITS   = 2'd2
  } rx_state_e;

  function automatic logic [3:0] clamp_data_len(input logic [3:0] len);
    if (len < 4'd5) return 4'd5;
    if (len > 4'd8) return 4'd8;
    return len;
  endfunction

  // Any code outside the known phase set behaves as idle.
  function automatic logic [3:0] legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_IDLE, CTRL_START, CTRL_DATA,
      CTRL_PARITY, CTRL_STOP0, CTRL_STOP1: return ctrl;
      default: return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rx_majority_sampler.sv
// RX line synchroniser plus a 3-sample window (current synchronised sample and
// the two previous tick samples) with a combinational majority vote.
module rx_majority_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic sample_tick,
  input  logic rx_in,
  output logic line_sync,
  output logic majority
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;

  // Synchroniser resets to the idle (high) line level.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q <= '1;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(rx_in);
    end
  end

  assign line_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      hist_q <= '0;
    end else if (sample_tick) begin
      hist_q <= {hist_q[0], line_sync};
    end
  end

  assign majority = (line_sync & hist_q[0]) |
                    (line_sync & hist_q[1]) |
                    (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/rx_shift_register.sv
// Oversampled serial receive datapath: start detection, centre sampling with
// majority vote, LSB-first shift-in, parity/stop checks and sticky status flags.
module rx_shift_register
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_MAX    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                sample_tick,
  input  logic                rx_in,
  input  logic [3:0]          ctrl_shift_register,
  input  logic [3:0]          number_data_receive,
  input  logic                parity_bit_mode,
  input  logic                parity_odd,
  input  logic                stop_bit_twice,
  output logic                start_bit,
  output logic                data_is_received,
  output logic                parity_bit,
  output logic                stop_bit,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_data_valid,
  output logic [1:0]          rx_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_MAX);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  rx_state_e           state, state_nx;
  logic [3:0]          ctrl_eff, ctrl_q;
  logic [CW-1:0]       cnt;
  logic [3:0]          bit_cnt, n_bits;
  logic [DATA_MAX-1:0] shift_q;
  logic                parity_acc;
  logic                line_sync, majority;
  logic                abort, start_seen, verify_tick, decide_tick;

  rx_majority_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .line_sync   (line_sync),
    .majority    (majority)
  );

  assign ctrl_eff    = legal_ctrl(ctrl_shift_register);
  assign abort       = (ctrl_eff == CTRL_IDLE);
  assign start_seen  = (state == HUNT) && sample_tick && (ctrl_eff == CTRL_START) && !line_sync;
  assign verify_tick = (state == VERIFY) && sample_tick && (cnt == CNT_HALF);
  assign decide_tick = (state == BITS) && sample_tick && (cnt == CNT_LAST);
  assign rx_state    = state;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= HUNT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    if (start_seen) state_nx = VERIFY;
      VERIFY:  if (verify_tick) state_nx = majority ? HUNT : BITS;
      BITS:    state_nx = BITS;
      default: state_nx = HUNT;
    endcase
    if (abort) state_nx = HUNT;
  end

  // In BITS the counter free-runs so bit alignment survives ctrl phase changes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (sample_tick) begin
      case (state)
        HUNT:    cnt <= start_seen ? CW'(1) : '0;
        VERIFY:  cnt <= verify_tick ? '0 : cnt + CW'(1);
        BITS:    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q           <= CTRL_IDLE;
      start_bit        <= 1'b0;
      data_is_received <= 1'b0;
      parity_bit       <= 1'b0;
      stop_bit         <= 1'b0;
      shift_q          <= '0;
      bit_cnt          <= '0;
      n_bits           <= '0;
      parity_acc       <= 1'b0;
      rx_data          <= '0;
      rx_data_valid    <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_eff;
      rx_data_valid <= 1'b0;
      if (abort) begin
        start_bit        <= 1'b0;
        data_is_received <= 1'b0;
        parity_bit       <= 1'b0;
        stop_bit         <= 1'b0;
        shift_q          <= '0;
        bit_cnt          <= '0;
        parity_acc       <= 1'b0;
      end else begin
        if (ctrl_eff == CTRL_STOP1 && ctrl_q == CTRL_STOP0) stop_bit <= 1'b0;
        if (verify_tick && !majority) begin
          start_bit <= 1'b1;
          n_bits    <= clamp_data_len(number_data_receive);
        end
        if (decide_tick) begin
          case (ctrl_eff)
            CTRL_DATA: begin
              if (!data_is_received) begin
                shift_q[bit_cnt[IW-1:0]] <= majority;
                parity_acc               <= parity_acc ^ majority;
                bit_cnt                  <= bit_cnt + 4'd1;
                if (bit_cnt + 4'd1 == n_bits) data_is_received <= 1'b1;
              end
            end
            CTRL_PARITY: begin
              if (parity_bit_mode) parity_bit <= (majority == (parity_acc ^ parity_odd));
            end
            CTRL_STOP0, CTRL_STOP1: begin
              stop_bit <= majority;
              if (majority && (ctrl_eff == CTRL_STOP1 || !stop_bit_twice)) begin
                rx_data       <= shift_q;
                rx_data_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed bench for rx_shift_register: table of whole frames plus hand-written
// false-start, abort and mid-frame reset sequences.
module tb_rx_shift_register;

  logic       PCLK;
  logic       PRESETn;
  logic       sample_tick;
  logic       rx_in;
  logic [3:0] ctrl_shift_register;
  logic [3:0] number_data_receive;
  logic       parity_bit_mode;
  logic       parity_odd;
  logic       stop_bit_twice;
  logic       start_bit;
  logic       data_is_received;
  logic       parity_bit;
  logic       stop_bit;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [1:0] rx_state;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;

  rx_shift_register #(.OVERSAMPLE(16), .DATA_MAX(8), .SYNC_STAGES(2)) dut (
    .PCLK                (PCLK),
    .PRESETn             (PRESETn),
    .sample_tick         (sample_tick),
    .rx_in               (rx_in),
    .ctrl_shift_register (ctrl_shift_register),
    .number_data_receive (number_data_receive),
    .parity_bit_mode     (parity_bit_mode),
    .parity_odd          (parity_odd),
    .stop_bit_twice      (stop_bit_twice),
    .start_bit           (start_bit),
    .data_is_received    (data_is_received),
    .parity_bit          (parity_bit),
    .stop_bit            (stop_bit),
    .rx_data             (rx_data),
    .rx_data_valid       (rx_data_valid),
    .rx_state            (rx_state)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (rx_data_valid) valid_cnt++;

  typedef struct {
    logic [7:0] data;
    logic [3:0] len_cfg;
    int         nbits;
    logic       par_en;
    logic       odd;
    logic       par_line;
    logic       two_stop;
    logic       stop0;
    logic       stop1;
    logic [3:0] idle_code;
    logic       exp_parity;
    logic       exp_stop;
    logic [7:0] exp_rx;
    int         exp_valid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One tick period is four PCLKs; rx_in settles through the synchroniser
  // before the tick edge, so that tick samples exactly 'line'.
  task automatic do_tick(input logic line);
    rx_in = line;
    repeat (3) @(negedge PCLK);
    sample_tick = 1'b1;
    @(negedge PCLK);
    sample_tick = 1'b0;
  endtask

  task automatic line_ticks(input logic line, input int n);
    for (int i = 0; i < n; i++) do_tick(line);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    number_data_receive = v.len_cfg;
    parity_odd          = v.odd;
    parity_bit_mode     = v.par_en;
    stop_bit_twice      = v.two_stop;
    base                = valid_cnt;
    ctrl_shift_register = 4'b0001;
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 16);
    check({tag, ".start"}, start_bit, 1);
    number_data_receive = v.len_cfg ^ 4'hF;
    ctrl_shift_register = 4'b0010;
    for (int i = 0; i < v.nbits; i++) line_ticks(v.data[i], 16);
    check({tag, ".data_rx"}, data_is_received, 1);
    if (v.par_en) begin
      ctrl_shift_register = 4'b0100;
      line_ticks(v.par_line, 16);
    end
    ctrl_shift_register = 4'b1000;
    line_ticks(v.stop0, 16);
    if (v.two_stop) begin
      check({tag, ".stop0"}, stop_bit, {31'd0, v.stop0});
      ctrl_shift_register = 4'b1001;
      @(negedge PCLK);
      check({tag, ".stop_clr"}, stop_bit, 0);
      line_ticks(v.stop1, 16);
    end
    check({tag, ".parity"}, parity_bit, {31'd0, v.exp_parity});
    check({tag, ".stop"}, stop_bit, {31'd0, v.exp_stop});
    check({tag, ".rx_data"}, rx_data, {24'd0, v.exp_rx});
    check({tag, ".valid_cnt"}, valid_cnt - base, v.exp_valid);
    ctrl_shift_register = v.idle_code;
    @(negedge PCLK);
    check({tag, ".idle_flags"}, {start_bit, data_is_received, parity_bit, stop_bit}, 0);
    check({tag, ".idle_keep"}, rx_data, {24'd0, v.exp_rx});
    check({tag, ".idle_state"}, rx_state, 0);
    line_ticks(1'b1, 2);
  endtask

  initial begin
    vec_t v;
    PRESETn             = 1'b0;
    sample_tick         = 1'b0;
    rx_in               = 1'b1;
    ctrl_shift_register = 4'b0000;
    number_data_receive = 4'd8;
    parity_bit_mode     = 1'b0;
    parity_odd          = 1'b0;
    stop_bit_twice      = 1'b0;

    //            data   cfg   n  pen odd pl two s0 s1 idle   ep   es   rx   nv
    vecs[0] = '{8'hA5, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hA5, 1};
    vecs[1] = '{8'h13, 4'd5,  5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h13, 1};
    vecs[2] = '{8'h13, 4'd5,  5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 8'h13, 1};
    vecs[3] = '{8'h66, 4'd8,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h13, 0};
    vecs[4] = '{8'h0A, 4'd3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b1, 8'h0A, 1};
    vecs[5] = '{8'hC3, 4'd15, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 8'hC3, 1};
    vecs[6] = '{8'h5B, 4'd7,  7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 8'h5B, 1};
    vecs[7] = '{8'hFF, 4'd6,  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h3F, 1};

    repeat (3) @(negedge PCLK);
    check("reset.flags", {start_bit, data_is_received, parity_bit, stop_bit}, 0);
    check("reset.rx_data", rx_data, 0);
    check("reset.valid", rx_data_valid, 0);
    check("reset.state", rx_state, 0);
    PRESETn = 1'b1;
    line_ticks(1'b1, 3);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // False start: a 4-tick glitch must not confirm a start bit.
    number_data_receive = 4'd8;
    parity_bit_mode     = 1'b0;
    stop_bit_twice      = 1'b0;
    ctrl_shift_register = 4'b0001;
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 2);
    check("false.verify", rx_state, 1);
    line_ticks(1'b0, 2);
    line_ticks(1'b1, 10);
    check("false.start", start_bit, 0);
    check("false.state", rx_state, 0);
    v = vecs[0]; v.data = 8'h3C; v.exp_rx = 8'h3C;
    run_vec(v, "after_false");

    // Abort after three data bits.
    number_data_receive = 4'd8;
    ctrl_shift_register = 4'b0001;
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 16);
    ctrl_shift_register = 4'b0010;
    line_ticks(1'b1, 16);
    line_ticks(1'b0, 16);
    line_ticks(1'b1, 16);
    check("abort.pre_start", start_bit, 1);
    ctrl_shift_register = 4'b0000;
    @(negedge PCLK);
    check("abort.flags", {start_bit, data_is_received, parity_bit, stop_bit}, 0);
    check("abort.state", rx_state, 0);
    check("abort.keep", rx_data, 8'h3C);
    line_ticks(1'b1, 4);
    v = vecs[0]; v.data = 8'h5A; v.exp_rx = 8'h5A;
    run_vec(v, "after_abort");

    // Asynchronous reset in the middle of the data bits.
    number_data_receive = 4'd8;
    ctrl_shift_register = 4'b0001;
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 16);
    ctrl_shift_register = 4'b0010;
    line_ticks(1'b1, 16);
    line_ticks(1'b0, 8);
    PRESETn = 1'b0;
    #1;
    check("rst.flags", {start_bit, data_is_received, parity_bit, stop_bit}, 0);
    check("rst.rx_data", rx_data, 0);
    check("rst.valid", rx_data_valid, 0);
    check("rst.state", rx_state, 0);
    ctrl_shift_register = 4'b0000;
    rx_in = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    line_ticks(1'b1, 3);
    v = vecs[0]; v.data = 8'hFF; v.exp_rx = 8'hFF;
    run_vec(v, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_shift_register.md
Name: rx_shift_register

Overview:
- Serial receive datapath that sits directly upstream of the RX control FSM.
- Synchronises the RX line, finds the start edge, and samples each bit at its centre using oversampling with a 3-sample majority vote.
- Shifts in 5–8 data bits LSB-first and checks parity and stop bits.
- Reports sticky status flags (start_bit, data_is_received, parity_bit, stop_bit) to the FSM, which drives the phase through ctrl_shift_register.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and ≥ 8.
- DATA_MAX, 8, width of rx_data and of the shift register.
- SYNC_STAGES, 2, flip-flop stages on rx_in.

Ports:
- PCLK  in  1  system clock; sole clock.
- PRESETn  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-PCLK enable at OVERSAMPLE × baud rate.
- rx_in  in  1  asynchronous serial line; idles high.
- ctrl_shift_register  in  4  phase from FSM: 0000 idle, 0001 start, 0010 data, 0100 parity, 1000 stop0, 1001 stop1.
- number_data_receive  in  4  data length; clamped to 5..8.
- parity_bit_mode  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- stop_bit_twice  in  1  1 = two stop bits.
- start_bit  out  1  sticky: valid start bit confirmed.
- data_is_received  out  1  sticky: all N data bits shifted in.
- parity_bit  out  1  sticky: parity checked and correct.
- stop_bit  out  1  sticky: current stop bit sampled high.
- rx_data  out  DATA_MAX  last completed word, right-justified, upper bits zero.
- rx_data_valid  out  1  one-PCLK pulse when a word completes.

Behaviour:
Reset:
- Synchroniser flops reset to 1; all other flops and counters reset to 0.
- All outputs reset to 0.
- Reset asserted mid-frame aborts the frame immediately; rx_data clears to 0.

General:
- Every counter and sampling action advances only on cycles with sample_tick=1.
- Flags change one PCLK after the deciding tick.
- Illegal ctrl codes are treated as 0000.

Internal state machine: HUNT, VERIFY, BITS.

HUNT:
- Entered from reset, and whenever ctrl=0000.
- Sample counter held at 0. If ctrl=0000 the block stays in HUNT and ignores the line.
- With ctrl=0001 and a tick where the synchronised line is 0: go to VERIFY, counter=1.

VERIFY:
- On the tick where counter=OVERSAMPLE/2, take the majority of the synchronised samples at counter OVERSAMPLE/2−2, −1 and 0.
- Majority 0: start_bit=1, counter=0, go to BITS.
- Majority 1: false start; return to HUNT, start_bit stays 0.

BITS:
- Counter wraps 0..OVERSAMPLE−1 continuously, independent of ctrl changes, so bit alignment is kept.
- Each bit is decided when counter=OVERSAMPLE−1, by majority of the samples at counter OVERSAMPLE−3..OVERSAMPLE−1.
- The decided bit is interpreted according to ctrl at the decision tick:
  - 0010: shift bit in LSB-first and update the running XOR. After N bits, data_is_received=1 and further 0010 decisions are ignored.
  - 0100: parity_bit = (bit == XOR(data) ^ parity_odd).
  - 1000 / 1001: stop_bit = bit.
    - If bit=1 and (ctrl=1001, or ctrl=1000 with stop_bit_twice=0): latch rx_data and pulse rx_data_valid.
    - If bit=0: no latch; remain in BITS until ctrl=0000.
- The ctrl transition 1000→1001 clears stop_bit before the second stop bit is decided.

Idle / abort:
- ctrl=0000 at any time clears all four flags, the shift register and the counters; state goes to HUNT.
- rx_data keeps its last value.
- If ctrl=0000 arrives on the same cycle as a decision tick, the abort wins.
- Frame completion never clears rx_data.
- number_data_receive is sampled at the start_bit confirmation and is ignored mid-frame.

Decomposition:
- Package uart_rx_pkg contains:
  - localparams for the ctrl encodings (CTRL_IDLE, CTRL_START, CTRL_DATA, CTRL_PARITY, CTRL_STOP0, CTRL_STOP1);
  - the typedef enum for HUNT/VERIFY/BITS;
  - a function that clamps the data length to 5..8.
- One sub-module, rx_majority_sampler: SYNC_STAGES synchroniser plus a 3-deep sample history advanced on sample_tick, with a combinational majority output.

Test Plan (OVERSAMPLE=16):
1. 8N1, 0xA5, ctrl stepped 0001→0010→1000 -> start_bit, then data_is_received after 8 bits; stop_bit=1; rx_data=0xA5; one rx_data_valid pulse.
2. 5E1, data 0x13, even parity bit 1 -> parity_bit=1; rx_data=0x13. Repeat with parity_odd=1 -> parity_bit=0.
3. Line low for 4 ticks, then high, ctrl=0001 -> start_bit stays 0; state returns to HUNT; next valid frame 0x3C is received correctly.
4. 8N2 with second stop bit driven 0 -> stop_bit=1 in stop0, cleared on 1001, stays 0; no rx_data_valid; rx_data keeps its previous value.
5. ctrl forced to 0000 after 3 data bits -> all flags 0 next cycle; following frame 0x5A decodes correctly.
6. PRESETn pulsed low mid-data -> all outputs 0 immediately; rx_data=0; recovery on next frame 0xFF.
